// File: rtl/merge_select_ctrl.sv
// Issue sequencer for one two-input merge stage. It picks the source FIFO from the
// head comparison flags, handles the zero-tuple terminator and counts tuples/streams.
module merge_select_ctrl #(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a_empty,
    input  logic             i_b_empty,
    input  logic             i_a_min_zero,
    input  logic             i_b_min_zero,
    input  logic             i_a_lte_b,
    input  logic             i_out_full,
    output logic             o_select_A,
    output logic             o_stall,
    output logic             o_switch_output,
    output logic             o_fwd,
    output logic             o_stream_done,
    output logic [CNT_W-1:0] o_tuple_cnt,
    output logic [CNT_W-1:0] o_stream_cnt
);

    localparam int unsigned INIT_W = 8;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_TERM_B = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic              last_a_q, last_a_d;
    logic              stream_done_q, stream_done_d;
    logic [CNT_W-1:0]  tuple_cnt_q, tuple_cnt_d;
    logic [CNT_W-1:0]  stream_cnt_q, stream_cnt_d;

    logic              select_a_c;
    logic              stall_c;
    logic              switch_c;
    logic              fwd_c;
    logic              both_term_c;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_INIT;
            init_cnt_q    <= '0;
            last_a_q      <= 1'b1;
            stream_done_q <= 1'b0;
            tuple_cnt_q   <= '0;
            stream_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            last_a_q      <= last_a_d;
            stream_done_q <= stream_done_d;
            tuple_cnt_q   <= tuple_cnt_d;
            stream_cnt_q  <= stream_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        last_a_d      = last_a_q;
        stream_done_d = 1'b0;
        tuple_cnt_d   = tuple_cnt_q;
        stream_cnt_d  = stream_cnt_q;
        select_a_c    = 1'b1;
        stall_c       = 1'b1;
        switch_c      = 1'b0;
        fwd_c         = 1'b0;
        both_term_c   = i_a_min_zero & i_b_min_zero;

        case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + INIT_W'(1);
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                stall_c = i_out_full | i_a_empty | i_b_empty;
                // A lone terminator acts as +inf so the other side drains first
                if (both_term_c) begin
                    select_a_c = 1'b1;
                end else if (i_a_min_zero) begin
                    select_a_c = 1'b0;
                end else if (i_b_min_zero) begin
                    select_a_c = 1'b1;
                end else begin
                    select_a_c = i_a_lte_b;
                end
                if (!stall_c) begin
                    fwd_c    = 1'b1;
                    switch_c = select_a_c ^ last_a_q;
                    last_a_d = select_a_c;
                    if (both_term_c) begin
                        state_d = S_TERM_B;
                    end else begin
                        tuple_cnt_d = tuple_cnt_q + CNT_W'(1);
                    end
                end
            end

            S_TERM_B: begin
                // Discard B's terminator; A's copy already went downstream
                select_a_c = 1'b0;
                stall_c    = i_b_empty | i_out_full;
                if (!stall_c) begin
                    stream_done_d = 1'b1;
                    stream_cnt_d  = stream_cnt_q + CNT_W'(1);
                    tuple_cnt_d   = '0;
                    state_d       = S_RUN;
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign o_select_A      = select_a_c;
    assign o_stall         = stall_c;
    assign o_switch_output = switch_c;
    assign o_fwd           = fwd_c;
    assign o_stream_done   = stream_done_q;
    assign o_tuple_cnt     = tuple_cnt_q;
    assign o_stream_cnt    = stream_cnt_q;

endmodule

// File: tb/tb_merge_select_ctrl.sv
// Directed bench for merge_select_ctrl: key queues stand in for the FIFOs, and each
// stream is checked against a hand-written issue sequence.
module tb_merge_select_ctrl;

    localparam int unsigned CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             a_empty, b_empty, a_min_zero, b_min_zero, a_lte_b, out_full;
    logic             o_select_A, o_stall, o_switch_output, o_fwd, o_stream_done;
    logic [CNT_W-1:0] o_tuple_cnt, o_stream_cnt;

    int n_vec = 0;
    int n_err = 0;
    int a_q[$];
    int b_q[$];
    logic full_v = 1'b0;

    merge_select_ctrl #(.INIT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_a_empty       (a_empty),
        .i_b_empty       (b_empty),
        .i_a_min_zero    (a_min_zero),
        .i_b_min_zero    (b_min_zero),
        .i_a_lte_b       (a_lte_b),
        .i_out_full      (out_full),
        .o_select_A      (o_select_A),
        .o_stall         (o_stall),
        .o_switch_output (o_switch_output),
        .o_fwd           (o_fwd),
        .o_stream_done   (o_stream_done),
        .o_tuple_cnt     (o_tuple_cnt),
        .o_stream_cnt    (o_stream_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Head-of-FIFO flags as the merge datapath would present them
    task automatic drive();
        a_empty    = (a_q.size() == 0);
        b_empty    = (b_q.size() == 0);
        a_min_zero = !a_empty && (a_q[0] == 0);
        b_min_zero = !b_empty && (b_q[0] == 0);
        a_lte_b    = (!a_empty && !b_empty) ? (a_q[0] <= b_q[0]) : 1'b0;
        out_full   = full_v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, o_stall, 1'b1);
        chk({tag, "_sel"}, o_select_A, 1'b1);
        chk({tag, "_fwd"}, o_fwd, 1'b0);
        chk({tag, "_sw"}, o_switch_output, 1'b0);
        chk({tag, "_done"}, o_stream_done, 1'b0);
        chk({tag, "_tcnt"}, o_tuple_cnt, 0);
        chk({tag, "_scnt"}, o_stream_cnt, 0);
    endtask

    task automatic init_check();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("init_stall%0d", i), o_stall, 1'b1);
            chk($sformatf("init_done%0d", i), o_stream_done, 1'b0);
            tick();
        end
    endtask

    // Walk issues until the expected sequence is used up; pops follow the expected source
    task automatic issue_seq(input string sel, input string fwd, input string sw,
                             input int exp_cnt);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < sel.len() && cyc < 50) begin
            if (!o_stall) begin
                chk($sformatf("sel%0d", k), o_select_A, sel.getc(k) == "A");
                chk($sformatf("fwd%0d", k), o_fwd, fwd.getc(k) == "1");
                chk($sformatf("sw%0d", k), o_switch_output, sw.getc(k) == "1");
                if (k == sel.len() - 1 && exp_cnt >= 0) begin
                    chk("tuple_cnt_peak", o_tuple_cnt, exp_cnt);
                end
                if (sel.getc(k) == "A") begin
                    if (a_q.size() > 0) void'(a_q.pop_front());
                end else begin
                    if (b_q.size() > 0) void'(b_q.pop_front());
                end
                k++;
            end
            tick();
            cyc++;
        end
        if (k < sel.len()) chk("issue_timeout", k, sel.len());
    endtask

    task automatic post_stream(input int exp_streams);
        chk("done_pulse", o_stream_done, 1'b1);
        chk("tuple_clear", o_tuple_cnt, 0);
        chk("stream_cnt", o_stream_cnt, exp_streams);
        tick();
        chk("done_low", o_stream_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        a_q = '{1, 3, 5, 0};
        b_q = '{2, 4, 6, 0};
        drive();
        #3;
        check_reset_outputs("rst");
        tick();
        tick();
        rst = 1'b0;
        init_check();

        // Interleaved stream with a terminator on both sides
        issue_seq("ABABABAB", "11111110", "01111110", 6);
        post_stream(1);

        // A holds only its terminator, so B drains first
        a_q = '{0};
        b_q = '{7, 8, 0};
        drive();
        #1;
        issue_seq("BBAB", "1110", "1010", 2);
        post_stream(2);

        // Downstream backpressure for three cycles mid-stream
        a_q = '{10, 30, 0};
        b_q = '{20, 0};
        drive();
        #1;
        issue_seq("A", "1", "0", -1);
        full_v = 1'b1;
        drive();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("full_stall%0d", i), o_stall, 1'b1);
            tick();
        end
        full_v = 1'b0;
        drive();
        #1;
        issue_seq("BAAB", "1110", "1100", 3);
        post_stream(3);

        // B empty while A holds a normal key
        a_q = '{5, 0};
        b_q.delete();
        drive();
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bempty_stall%0d", i), o_stall, 1'b1);
            tick();
        end
        b_q = '{6, 0};
        drive();
        #1;
        issue_seq("ABAB", "1110", "0110", 2);
        post_stream(4);

        // Reset while waiting to pop B's terminator
        a_q = '{0};
        b_q = '{0};
        drive();
        #1;
        issue_seq("A", "1", "0", -1);
        chk("termb_sel", o_select_A, 1'b0);
        chk("termb_stall", o_stall, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst = 1'b0;
        a_q = '{1, 0};
        b_q = '{0};
        drive();
        #1;
        init_check();
        issue_seq("AAB", "110", "000", 1);
        post_stream(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/merge_select_ctrl.md
Name: merge_select_ctrl

Overview:
- Sequencing controller for one two-input merge stage: head FIFO A, head FIFO B, then a two-stage bitonic network into an output FIFO.
- Each cycle it decides whether a tuple is issued, and from which input FIFO, using the head-of-FIFO comparison flags.
- It handles the zero-tuple end-of-stream terminator and throttles on downstream backpressure.
- It also counts issued tuples and completed streams for status.

Parameters:
- INIT_CYCLES, 4: stall cycles after reset release before the first issue. Covers pipeline fill. Legal range 1..255.
- CNT_W, 32: width of the tuple and stream counters.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_a_empty  in  1  FIFO A empty.
- i_b_empty  in  1  FIFO B empty.
- i_a_min_zero  in  1  FIFO A head is the terminator (all-zero tuple).
- i_b_min_zero  in  1  FIFO B head is the terminator.
- i_a_lte_b  in  1  A head key <= B head key.
- i_out_full  in  1  downstream cannot accept; stall.
- o_select_A  out  1  1 = A is the issue source, 0 = B.
- o_stall  out  1  1 = no issue this cycle.
- o_switch_output  out  1  issue source differs from the previous issue's source.
- o_fwd  out  1  issued tuple enters the network. 0 = discarded pop.
- o_stream_done  out  1  one-cycle pulse, registered.
- o_tuple_cnt  out  CNT_W  forwarded tuples in the current stream.
- o_stream_cnt  out  CNT_W  completed streams since reset.

Behaviour:
- Dequeue rule: the selected FIFO dequeues on every cycle with o_stall=0 (the issue cycle). Decision outputs are combinational from state and inputs; all state is registered.
- Reset values: state=S_INIT, init counter=0, o_stream_done=0, o_tuple_cnt=0, o_stream_cnt=0, last-source=A. While in reset, o_stall=1, o_select_A=1, o_fwd=0, o_switch_output=0.
- S_INIT: o_stall=1. Counter increments each cycle. At INIT_CYCLES-1 → S_RUN. The first issue is possible exactly INIT_CYCLES cycles after reset deassert.
- S_RUN stall conditions: o_stall=1 if i_out_full, or i_a_empty, or i_b_empty (both heads are required to compare).
- S_RUN selection, in priority order:
  - a_min_zero & b_min_zero → select A, fwd=1 (terminator forwarded once), next S_TERM_B.
  - a_min_zero only → select B (terminator treated as +inf).
  - b_min_zero only → select A.
  - else → select A if i_a_lte_b, otherwise B.
- S_RUN on a non-terminal issue: o_fwd=1, o_tuple_cnt += 1 (wraps mod 2^CNT_W).
- S_TERM_B: pops B's terminator. o_select_A=0, o_fwd=0, o_stall = i_b_empty | i_out_full.
- S_TERM_B on issue, next cycle:
  - o_stream_done=1 for exactly one cycle.
  - o_stream_cnt += 1 (wraps).
  - o_tuple_cnt ← 0.
  - next state S_RUN.
- S_TERM_B does not sample i_b_min_zero; the head is unchanged since the decision.
- o_switch_output: on issue cycles = (o_select_A != last-source). Last-source updates only on issue cycles. Forced 0 in S_TERM_B, and S_TERM_B does not update last-source.
- Simultaneous events: i_out_full dominates every issue decision. Empty flags are sampled in the same cycle and have no lookahead.
- Async reset mid-stream: immediate return to S_INIT with all counters cleared. Tuples already in the FIFOs are untouched; the datapath is flushed externally.
- The terminator from A is the only terminator forwarded per stream. Forwarded count excludes terminators.

Test Plan:
- Reset release, INIT_CYCLES=4, both FIFOs non-empty → o_stall=1 for cycles 0-3; first issue at cycle 4.
- A keys {1,3,5,0}, B keys {2,4,6,0}, out never full → select sequence A,B,A,B,A,B,A(term),B(term, fwd=0). o_switch_output=1 on issues 2-7. o_stream_done pulses once. o_tuple_cnt reaches 6 then clears to 0. o_stream_cnt=1.
- A={0}, B={7,8,0} → B,B issued with fwd=1; then A terminator; then B terminator. o_tuple_cnt=2 before clear.
- Mid-run: i_out_full=1 for 3 cycles → o_stall=1 and no dequeue for those 3 cycles. Selection resumes identically afterwards.
- B empty for 5 cycles while A non-empty (non-terminal) → o_stall=1 throughout. No A dequeue.
- i_rst pulsed during S_TERM_B → outputs return to reset values asynchronously. No o_stream_done pulse. The INIT sequence restarts.
